// File: rtl/prbs_checker.sv
// prbs_checker: PRBS7 (x^7 + x^6 + 1) serial bitstream checker.
// It searches for lock by loading the incoming bits into a 7-bit shift
// register and counting consecutive correct predictions. Once locked, the
// register runs free on its own predictions, and each incoming bit is
// compared against it. Errors are counted per window, and the checker drops
// back to SEARCH when too many errors fall into one window.

module prbs_checker #(
  parameter int LOCK_RUN  = 16,
  parameter int LOSS_ERRS = 4,
  parameter int WINDOW    = 32,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in,
  input  logic          clear,
  output logic          locked,
  output logic          error,
  output logic [CW-1:0] err_count
);

  // Counter widths. Each one is sized to hold its terminal value.
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Reference shift register. s[6] is the oldest bit and s[0] is the newest.
  logic [6:0]    s;
  // Number of bits loaded since the last entry into SEARCH (saturates at 7).
  logic [2:0]    fill;
  // Consecutive correct predictions while searching.
  logic [RW-1:0] run_cnt;
  // Position inside the current lock-monitor window.
  logic [WW-1:0] win_cnt;
  // Mismatches seen in the current window.
  logic [EW-1:0] win_err;

  logic          p;
  logic          match;
  logic          mismatch;
  logic          lock_hit;
  logic          loss_hit;
  logic          win_last;
  logic          count_err;
  logic [RW-1:0] run_inc;
  logic [EW-1:0] win_err_inc;

  // Decode the predicted bit and the events this enabled bit would trigger.
  always_comb begin
    p           = s[6] ^ s[5];
    match       = (fill == 3'd7) && (s != 7'd0) && (in == p);
    mismatch    = (in != p);
    run_inc     = run_cnt + RW'(1);
    lock_hit    = ena && (state == SEARCH) && match && (run_inc == RW'(LOCK_RUN));
    win_err_inc = win_err + EW'(mismatch);
    loss_hit    = ena && (state == LOCKED) && (win_err_inc == EW'(LOSS_ERRS));
    win_last    = (win_cnt == WW'(WINDOW - 1));
    count_err   = ena && (state == LOCKED) && mismatch;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: lock on the run target, and unlock on window overflow.
  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (lock_hit) state_next = LOCKED;
      LOCKED:  if (loss_hit) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  // Output decode. The lock flag comes straight from the state register.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Shift register and the fill, run and window counters. All of them
  // advance only on enabled bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s       <= '0;
      fill    <= '0;
      run_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
    end else if (ena) begin
      if (state == SEARCH) begin
        s <= {s[5:0], in};
        if (fill != 3'd7) begin
          fill <= fill + 3'd1;
        end
        if (match && !lock_hit) begin
          run_cnt <= run_inc;
        end else begin
          run_cnt <= '0;
        end
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        s <= {s[5:0], p};
        if (loss_hit) begin
          fill    <= '0;
          run_cnt <= '0;
          win_cnt <= '0;
          win_err <= '0;
        end else if (win_last) begin
          win_cnt <= '0;
          win_err <= EW'(mismatch);
        end else begin
          win_cnt <= win_cnt + WW'(1);
          win_err <= win_err_inc;
        end
      end
    end
  end

  // Registered one-cycle error pulse for each mismatch while locked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error <= 1'b0;
    end else begin
      error <= count_err;
    end
  end

  // Saturating mismatch total. A clear on the same edge as a counted
  // mismatch wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (count_err && (err_count != '1)) begin
      err_count <= err_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed and randomized checks of prbs_checker against a
// bit-history reference model. A second instance built with CW = 2 covers
// counter saturation.

module tb_prbs_checker;

  localparam int LOCK_RUN  = 16;
  localparam int LOSS_ERRS = 4;
  localparam int WINDOW    = 32;
  localparam int CW        = 16;
  localparam int MAX16     = 65535;
  localparam int MAX2      = 3;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic ena    = 1'b0;
  logic in_bit = 1'b0;
  logic clear  = 1'b0;

  logic          locked;
  logic          error;
  logic [CW-1:0] err_count;
  logic          locked2;
  logic          error2;
  logic [1:0]    err_count2;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the last seven reference bits, oldest first.
  bit hist[$];
  bit m_locked;
  bit m_error;
  int m_fill;
  int m_run;
  int m_win;
  int m_winerr;
  int m_err16;
  int m_err2;

  // Stimulus generator state.
  bit [6:0] gen = 7'h01;

  always #5 clk = ~clk;

  prbs_checker #(
    .LOCK_RUN (LOCK_RUN),
    .LOSS_ERRS(LOSS_ERRS),
    .WINDOW   (WINDOW),
    .CW       (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in       (in_bit),
    .clear    (clear),
    .locked   (locked),
    .error    (error),
    .err_count(err_count)
  );

  prbs_checker #(
    .LOCK_RUN (LOCK_RUN),
    .LOSS_ERRS(LOSS_ERRS),
    .WINDOW   (WINDOW),
    .CW       (2)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in       (in_bit),
    .clear    (clear),
    .locked   (locked2),
    .error    (error2),
    .err_count(err_count2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 7; i++) hist.push_back(1'b0);
    m_locked = 0; m_error = 0;
    m_fill = 0; m_run = 0; m_win = 0; m_winerr = 0;
    m_err16 = 0; m_err2 = 0;
  endtask

  task automatic model_step(input bit e, input bit b, input bit c);
    bit pred;
    bit nonzero;
    bit mis;
    m_error = 0;
    if (e) begin
      pred = hist[0] ^ hist[1];
      if (!m_locked) begin
        nonzero = 0;
        foreach (hist[i]) if (hist[i]) nonzero = 1;
        hist.push_back(b);
        void'(hist.pop_front());
        if (m_fill == 7 && nonzero && b == pred) m_run++;
        else m_run = 0;
        if (m_fill < 7) m_fill++;
        if (m_run == LOCK_RUN) begin
          m_locked = 1; m_run = 0; m_win = 0; m_winerr = 0;
        end
      end else begin
        mis = (b != pred);
        hist.push_back(pred);
        void'(hist.pop_front());
        m_error = mis;
        if (mis) begin
          if (m_err16 < MAX16) m_err16++;
          if (m_err2 < MAX2) m_err2++;
        end
        m_winerr += int'(mis);
        if (m_winerr == LOSS_ERRS) begin
          m_locked = 0; m_fill = 0; m_run = 0; m_win = 0; m_winerr = 0;
        end else if (m_win == WINDOW - 1) begin
          m_win = 0; m_winerr = int'(mis);
        end else begin
          m_win++;
        end
      end
    end
    if (c) begin
      m_err16 = 0; m_err2 = 0;
    end
  endtask

  task automatic gen_bit(output bit b);
    b = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  task automatic applyStimulus(input bit e, input bit b, input bit c);
    @(negedge clk);
    ena = e; in_bit = b; clear = c;
    @(posedge clk);
    model_step(e, b, c);
    #1;
    checkOutput("locked", 32'(locked), 32'(m_locked));
    checkOutput("error", 32'(error), 32'(m_error));
    checkOutput("err_count", 32'(err_count), 32'(m_err16));
    checkOutput("locked_cw2", 32'(locked2), 32'(m_locked));
    checkOutput("error_cw2", 32'(error2), 32'(m_error));
    checkOutput("err_count_cw2", 32'(err_count2), 32'(m_err2));
  endtask

  task automatic drive(input bit e, input bit flip, input bit c);
    bit b;
    if (e) begin
      gen_bit(b);
      b = b ^ flip;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    applyStimulus(e, b, c);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; ena = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitLock(input int max_cyc, input bit toggle, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      drive(toggle ? bit'(i % 2 == 0) : 1'b1, 1'b0, 1'b0);
      if (locked === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic alignWindow();
    int n = 0;
    while (!(m_locked && m_win == 0 && m_winerr == 0) && n < 3 * WINDOW) begin
      drive(1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("window_align", 32'(m_locked && m_win == 0 && m_winerr == 0), 32'd1);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence followed by a randomized phase.
  initial begin
    int cyc;
    int pulses;
    int o1, o2, o3, o4;

    model_reset();
    doReset();

    // Clean stream from seed 1: lock after 23 bits, with no errors over 200 bits.
    gen = 7'h01;
    waitLock(200, 1'b0, cyc);
    checkOutput("lock_latency", 32'(cyc), 32'd23);
    for (int i = cyc; i < 200; i++) drive(1'b1, 1'b0, 1'b0);
    checkOutput("clean_err_count", 32'(err_count), 32'd0);

    // Three isolated flips inside one window.
    alignWindow();
    o1 = int'($urandom_range(0, 7));
    o2 = o1 + 2 + int'($urandom_range(0, 7));
    o3 = o2 + 2 + int'($urandom_range(0, 7));
    pulses = 0;
    for (int k = 0; k < WINDOW; k++) begin
      drive(1'b1, bit'(k == o1 || k == o2 || k == o3), 1'b0);
      if (error === 1'b1) pulses++;
    end
    checkOutput("three_flip_pulses", 32'(pulses), 32'd3);
    checkOutput("three_flip_count", 32'(err_count), 32'd3);
    checkOutput("three_flip_locked", 32'(locked), 32'd1);

    // Clear, then four flips inside one window: lock is lost and then regained.
    drive(1'b1, 1'b0, 1'b1);
    alignWindow();
    o1 = int'($urandom_range(0, 5));
    o2 = o1 + 1 + int'($urandom_range(0, 5));
    o3 = o2 + 1 + int'($urandom_range(0, 5));
    o4 = o3 + 1 + int'($urandom_range(0, 5));
    for (int k = 0; k <= o4; k++) begin
      drive(1'b1, bit'(k == o1 || k == o2 || k == o3 || k == o4), 1'b0);
    end
    checkOutput("loss_locked", 32'(locked), 32'd0);
    checkOutput("loss_count", 32'(err_count), 32'd4);
    checkOutput("loss_count_cw2_sat", 32'(err_count2), 32'd3);
    waitLock(100, 1'b0, cyc);
    checkOutput("relock_latency", 32'(cyc), 32'd23);

    // A clear on the same edge as a counted mismatch leaves the count at zero.
    drive(1'b1, 1'b1, 1'b1);
    checkOutput("clear_wins_count", 32'(err_count), 32'd0);
    checkOutput("clear_wins_error", 32'(error), 32'd1);

    // Randomized phase: sparse ena gaps, random flips and random clears.
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 19) == 0),
            bit'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset in the middle of LOCKED, with the error pulse and
    // the count both live.
    waitLock(100, 1'b0, cyc);
    if (!m_locked) checkOutput("prereset_lock", 32'(locked), 32'd1);
    drive(1'b1, 1'b1, 1'b0);
    checkOutput("prereset_error", 32'(error), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_error", 32'(error), 32'd0);
    checkOutput("async_err_count", 32'(err_count), 32'd0);
    checkOutput("async_err_count_cw2", 32'(err_count2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    waitLock(100, 1'b0, cyc);
    checkOutput("post_reset_lock_latency", 32'(cyc), 32'd23);

    // ena toggling every cycle: 23 enabled bits take 46 cycles.
    doReset();
    pulses = 0;
    waitLock(100, 1'b1, cyc);
    checkOutput("toggle_lock_cycles", 32'(cyc), 32'd46);
    for (int i = 0; i < 40; i++) begin
      drive(bit'(i % 2 == 1), 1'b0, 1'b0);
      if (error === 1'b1) pulses++;
    end
    checkOutput("toggle_no_error", 32'(pulses), 32'd0);

    // An all-zero input never locks.
    doReset();
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("zero_locked", 32'(locked), 32'd0);
    checkOutput("zero_err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_RUN, default 16, means the number of consecutive correct predictions needed to declare lock.
REQ-002 Parameter LOSS_ERRS, default 4, means the error count within one window that causes loss of lock.
REQ-003 Parameter WINDOW, default 32, means the length of the lock-monitor window, in enabled bits.
REQ-004 Parameter CW, default 16, means the width of err_count.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port ena, input, 1 bit: when high, `in` is a valid serial bit this cycle.
REQ-008 Port in, input, 1 bit: serial PRBS7 bitstream under test, the same stream the team's LFSR pattern generator drives on its `out`.
REQ-009 Port clear, input, 1 bit: synchronous clear of err_count.
REQ-010 Port locked, output, 1 bit: high while the checker is in state LOCKED.
REQ-011 Port error, output, 1 bit: one-cycle pulse for each mismatched bit while locked.
REQ-012 Port err_count, output, CW bits: saturating total of mismatches while locked.

Function
REQ-013 Polynomial: x^7+x^6+1; 7-bit register s; predicted bit p = s[6]^s[5]; shift is s <= {s[5:0], b}.
REQ-014 ena low: no state, register or counter changes; error driven 0 next cycle.
REQ-015 FSM states: SEARCH, LOCKED; reset state SEARCH.
REQ-016 SEARCH, enabled bit: shift `in` into s (b = in); fill counter increments, saturating at 7.
REQ-017 SEARCH match rule: a bit counts as a match only if fill == 7 before the shift, s != 0, and in == p; run counter +1, else run counter <= 0.
REQ-018 SEARCH -> LOCKED: on the enabled bit that brings the run counter to LOCK_RUN; locked is high from the next cycle.
REQ-019 LOCKED, enabled bit: s shifts in the predicted bit (b = p, free-running reference), not `in`; the mismatch condition is in != p.
REQ-020 LOCKED mismatch: error = 1 in the cycle after the sampling edge (1-cycle latency); err_count +1, holding at 2^CW-1 (no wrap).
REQ-021 Window: window counter counts enabled bits in LOCKED, 0..WINDOW-1, and wraps to 0; window error counter counts mismatches in the current window.
REQ-022 LOCKED -> SEARCH: as soon as window errors reach LOSS_ERRS (on that edge); fill, run, window counters and window errors <= 0; s is kept; err_count is kept.
REQ-023 Window wrap without loss: window error counter <= 0 (or 1 if the wrapping bit itself mismatched).
REQ-024 Zero-lock guard: an all-zero input stream never achieves lock (per REQ-017).
REQ-025 clear: err_count <= 0 on the edge; if a counted mismatch occurs on the same edge, clear wins (err_count = 0); error is unaffected.
REQ-026 clear has no effect on FSM, s, or window counters.
REQ-027 Outputs are registered; no combinational path from in/ena to outputs.

Reset
REQ-028 rst low asynchronously forces: state SEARCH, s = 0, fill = run = 0, window counters = 0, locked = 0, error = 0, err_count = 0.
REQ-029 Reset asserted mid-LOCKED drops locked immediately (no clock needed); after release, lock requires a full 7 + LOCK_RUN enabled bits again.
REQ-030 Reset release is a synchronous deassertion by the environment; the first enabled bit after release is a fill bit.

Verification
REQ-031 Clean PRBS7 (generator seed 7'h01), ena = 1 continuously: locked rises the cycle after the 23rd bit; err_count stays 0 for 200 bits.
REQ-032 Lock, then flip 3 isolated bits within one 32-bit window: 3 single-cycle error pulses, err_count = 3, locked stays 1.
REQ-033 Lock, then flip 4 bits within one window: locked falls after the 4th flip, err_count = 4; the clean stream relocks after 23 more bits.
REQ-034 ena toggled 1/0 every cycle on a clean stream: locked after 23 enabled bits (46 cycles); error never pulses.
REQ-035 All-zero input for 100 bits: locked stays 0, err_count stays 0; pulsing clear together with a mismatch leaves err_count = 0.
REQ-036 Preload err_count to 2^CW-1 (force or CW = 2 build) and inject a mismatch: err_count holds at max; rst low mid-stream gives all outputs 0 with no clock edge.
